// File: rtl/dac_cmd_pkg.sv
// Shared constants and types for the sweep DAC command parser.
// Covers frame bytes, opcodes, NACK detail codes and the parser state encoding.
package dac_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NACK_BYTE = 8'h15;

    localparam logic [7:0] CMD_SET_SWEEP = 8'h01;
    localparam logic [7:0] CMD_RUN       = 8'h02;
    localparam logic [7:0] CMD_STOP      = 8'h03;
    localparam logic [7:0] CMD_STATUS    = 8'h04;

    localparam logic [7:0] DET_OK      = 8'h00;
    localparam logic [7:0] DET_BAD_CHK = 8'h01;
    localparam logic [7:0] DET_BUSY    = 8'h02;
    localparam logic [7:0] DET_BAD_ARG = 8'h03;
    localparam logic [7:0] DET_BAD_CMD = 8'h04;

    localparam int FRAME_LEN = 6;

    typedef enum logic [3:0] {
        ST_HUNT, ST_CMD, ST_A0, ST_A1, ST_A2, ST_CHK, ST_EXEC, ST_RESP0, ST_RESP1
    } parserState_e;

endpackage

// File: rtl/dac_cmd_responder.sv
// Two-byte TX holding register: loaded with {code, detail}, then presents
// both bytes in order under a valid/ready handshake.
module dac_cmd_responder
    import dac_cmd_pkg::*;
(
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic       load,
    input  logic [7:0] loadCode,
    input  logic [7:0] loadDetail,
    input  logic       ipTxReady,
    output logic [7:0] opTxData,
    output logic       opTxValid,
    output logic       txFire
);

    logic [7:0] detailHold;
    logic       secondByte;

    assign txFire = opTxValid && ipTxReady;

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            opTxValid  <= 1'b0;
            opTxData   <= '0;
            detailHold <= '0;
            secondByte <= 1'b0;
        end else if (load) begin
            opTxValid  <= 1'b1;
            opTxData   <= loadCode;
            detailHold <= loadDetail;
            secondByte <= 1'b0;
        end else if (txFire) begin
            // Valid stays high across the code->detail switch.
            if (secondByte) begin
                opTxValid <= 1'b0;
            end else begin
                opTxData   <= detailHold;
                secondByte <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_cmd_parser.sv
// Framed command parser feeding sweep configuration and run control to the DAC driver.
//   state  | meaning
//   HUNT   | wait for SYNC, discard anything else
//   CMD..  | collect CMD, A0, A1, A2 with running XOR
//   CHK    | compare checksum byte against XOR
//   EXEC   | decode, update registers atomically, load responder
//   RESP0/1| wait for each response byte to be accepted
module dac_cmd_parser
    import dac_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] RST_START      = 8'd1,
    parameter logic [7:0] RST_END        = 8'd64,
    parameter logic [7:0] RST_STEP       = 8'd1
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic [7:0] ipRxData,
    input  logic       ipRxValid,
    output logic [7:0] opTxData,
    output logic       opTxValid,
    input  logic       ipTxReady,
    output logic [7:0] opStartFreq,
    output logic [7:0] opEndFreq,
    output logic [7:0] opStep,
    output logic [1:0] opControl,
    output logic       opOverrun
);

    localparam int            TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    parserState_e  state;
    logic [7:0]    cmdReg, a0Reg, a1Reg, a2Reg, xorAcc;
    logic          chkOk;
    logic [TW-1:0] idleCnt;
    logic [7:0]    respCode, respDetail;
    logic          doSweep, doRun, doStop, doStatus;
    logic          txFire;
    logic          inResp;

    assign inResp = (state == ST_EXEC) || (state == ST_RESP0) || (state == ST_RESP1);

    always_comb begin
        respCode   = ACK_BYTE;
        respDetail = DET_OK;
        doSweep    = 1'b0;
        doRun      = 1'b0;
        doStop     = 1'b0;
        doStatus   = 1'b0;
        if (!chkOk) begin
            respCode   = NACK_BYTE;
            respDetail = DET_BAD_CHK;
        end else begin
            case (cmdReg)
                CMD_SET_SWEEP: begin
                    // Config only latches at DAC start, so refuse while running.
                    if (opControl[0]) begin
                        respCode   = NACK_BYTE;
                        respDetail = DET_BUSY;
                    end else if (a0Reg > a1Reg || a2Reg == 8'd0) begin
                        respCode   = NACK_BYTE;
                        respDetail = DET_BAD_ARG;
                    end else begin
                        doSweep = 1'b1;
                    end
                end
                CMD_RUN: begin
                    if (opStartFreq > opEndFreq || opStep == 8'd0) begin
                        respCode   = NACK_BYTE;
                        respDetail = DET_BAD_ARG;
                    end else begin
                        doRun = 1'b1;
                    end
                end
                CMD_STOP:   doStop = 1'b1;
                CMD_STATUS: begin
                    doStatus   = 1'b1;
                    respDetail = {opOverrun, 5'b0, opControl};
                end
                default: begin
                    respCode   = NACK_BYTE;
                    respDetail = DET_BAD_CMD;
                end
            endcase
        end
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state       <= ST_HUNT;
            cmdReg      <= '0;
            a0Reg       <= '0;
            a1Reg       <= '0;
            a2Reg       <= '0;
            xorAcc      <= '0;
            chkOk       <= 1'b0;
            idleCnt     <= '0;
            opStartFreq <= RST_START;
            opEndFreq   <= RST_END;
            opStep      <= RST_STEP;
            opControl   <= 2'b00;
            opOverrun   <= 1'b0;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (ipRxValid && ipRxData == SYNC_BYTE) begin
                        state   <= ST_CMD;
                        xorAcc  <= '0;
                        idleCnt <= TO_LOAD;
                    end
                end
                ST_CMD, ST_A0, ST_A1, ST_A2, ST_CHK: begin
                    // An arriving byte beats an expiring idle timer.
                    if (ipRxValid) begin
                        idleCnt <= TO_LOAD;
                        xorAcc  <= xorAcc ^ ipRxData;
                        case (state)
                            ST_CMD: begin cmdReg <= ipRxData; state <= ST_A0; end
                            ST_A0:  begin a0Reg  <= ipRxData; state <= ST_A1; end
                            ST_A1:  begin a1Reg  <= ipRxData; state <= ST_A2; end
                            ST_A2:  begin a2Reg  <= ipRxData; state <= ST_CHK; end
                            default: begin
                                chkOk <= (xorAcc == ipRxData);
                                state <= ST_EXEC;
                            end
                        endcase
                    end else if (idleCnt == '0) begin
                        state <= ST_HUNT;
                    end else begin
                        idleCnt <= idleCnt - TW'(1);
                    end
                end
                ST_EXEC: begin
                    state <= ST_RESP0;
                    if (doSweep) begin
                        opStartFreq <= a0Reg;
                        opEndFreq   <= a1Reg;
                        opStep      <= a2Reg;
                    end
                    if (doRun)  opControl    <= {a0Reg[1], 1'b1};
                    if (doStop) opControl[0] <= 1'b0;
                end
                ST_RESP0: if (txFire) state <= ST_RESP1;
                ST_RESP1: if (txFire) state <= ST_HUNT;
                default:  state <= ST_HUNT;
            endcase

            if (ipRxValid && inResp)
                opOverrun <= 1'b1;
            else if (state == ST_EXEC && doStatus)
                opOverrun <= 1'b0;
        end
    end

    dac_cmd_responder uResponder (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .load       (state == ST_EXEC),
        .loadCode   (respCode),
        .loadDetail (respDetail),
        .ipTxReady  (ipTxReady),
        .opTxData   (opTxData),
        .opTxValid  (opTxValid),
        .txFire     (txFire)
    );

endmodule
